// File: rtl/vc_pkg.sv
// Shared constants, types and helpers for the per-VC request tracker.
package vc_pkg;
  localparam int NUM_VC = 8;
  localparam int VC_W   = 3;
  localparam int GNT_W  = NUM_VC;

  typedef logic [VC_W-1:0] vc_id_t;

  // True when exactly one bit of the grant vector is set.
  function automatic logic onehot_valid(input logic [GNT_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/vc_counter.sv
// Saturating up/down pending-packet counter for one virtual channel.
module vc_counter #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          nonzero,
  output logic          full,
  output logic          underflow
);
  logic do_inc;
  logic do_dec;

  assign nonzero   = (cnt != '0);
  assign full      = (cnt == CW'(DEPTH));
  // A refused increment and a blocked decrement never change the count.
  assign do_inc    = inc && !full;
  assign do_dec    = dec && nonzero;
  assign underflow = dec && !nonzero;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (do_inc && !do_dec) begin
      cnt <= cnt + 1'b1;
    end else if (do_dec && !do_inc) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/vc_req_tracker.sv
// Tracks pending packets per VC and drives the arbiter request vector;
// one-hot grants retire one packet per cycle.
module vc_req_tracker
  import vc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 pkt_valid,
  input  logic [2:0]           pkt_vc,
  output logic                 pkt_ready,
  input  logic [7:0]           gnt,
  output logic [7:0]           req,
  output logic [7:0]           full,
  output logic [CW+2:0]        total,
  output logic                 err,
  output logic [NUM_VC*CW-1:0] cnt
);
  logic [NUM_VC-1:0] inc;
  logic [NUM_VC-1:0] dec;
  logic [NUM_VC-1:0] nonzero;
  logic [NUM_VC-1:0] underflow;
  logic              gnt_ok;
  logic              gnt_bad;
  logic              acc;
  logic              eff;
  logic              drop;

  assign gnt_ok    = onehot_valid(gnt);
  assign gnt_bad   = (gnt != '0) && !gnt_ok;
  assign pkt_ready = !full[pkt_vc];
  assign acc       = pkt_valid && pkt_ready;
  assign drop      = pkt_valid && !pkt_ready;
  assign eff       = gnt_ok && ((gnt & nonzero) != '0);
  assign req       = nonzero;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      inc[i] = pkt_valid && (pkt_vc == vc_id_t'(i));
      dec[i] = gnt_ok && gnt[i];
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    vc_counter #(.DEPTH(DEPTH), .CW(CW)) u_cnt (
      .clk       (clk),
      .clr       (clr),
      .inc       (inc[g]),
      .dec       (dec[g]),
      .cnt       (cnt[g*CW +: CW]),
      .nonzero   (nonzero[g]),
      .full      (full[g]),
      .underflow (underflow[g])
    );
  end

  // At most one accepted arrival and one effective grant per cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      total <= '0;
    end else if (acc && !eff) begin
      total <= total + 1'b1;
    end else if (eff && !acc) begin
      total <= total - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err <= 1'b0;
    end else if (drop || gnt_bad || (underflow != '0)) begin
      err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vc_req_tracker.sv
// Directed and randomized checks of vc_req_tracker against a count model.
module tb_vc_req_tracker;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int NV    = 8;

  logic             clk = 1'b0;
  logic             clr;
  logic             pkt_valid;
  logic [2:0]       pkt_vc;
  logic             pkt_ready;
  logic [7:0]       gnt;
  logic [7:0]       req;
  logic [7:0]       full;
  logic [CW+2:0]    total;
  logic             err;
  logic [NV*CW-1:0] cnt;

  int mcnt [NV];
  bit merr;
  int n_tests = 0;
  int n_fail  = 0;

  vc_req_tracker #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .clr(clr), .pkt_valid(pkt_valid), .pkt_vc(pkt_vc),
    .pkt_ready(pkt_ready), .gnt(gnt), .req(req), .full(full),
    .total(total), .err(err), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) mcnt[i] = 0;
    merr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0]       e_req;
    logic [7:0]       e_full;
    logic [NV*CW-1:0] e_cnt;
    int               sum;
    e_req = '0; e_full = '0; e_cnt = '0; sum = 0;
    for (int i = 0; i < NV; i++) begin
      e_req[i]  = (mcnt[i] > 0);
      e_full[i] = (mcnt[i] == DEPTH);
      e_cnt[i*CW +: CW] = CW'(mcnt[i]);
      sum += mcnt[i];
    end
    check({tag, ".req"},   64'(req),   64'(e_req));
    check({tag, ".full"},  64'(full),  64'(e_full));
    check({tag, ".total"}, 64'(total), 64'(sum));
    check({tag, ".err"},   64'(err),   64'(merr));
    check({tag, ".cnt"},   64'(cnt),   64'(e_cnt));
  endtask

  // One clock cycle: drive, check pkt_ready, clock, update model, check state.
  task automatic step(input string tag, input logic v, input logic [2:0] vc,
                      input logic [7:0] g, input bit full_check);
    bit acc, eff;
    int gi, ones;
    pkt_valid = v; pkt_vc = vc; gnt = g;
    #1;
    check({tag, ".ready"}, 64'(pkt_ready), 64'(mcnt[vc] != DEPTH));
    @(posedge clk);
    acc = v && (mcnt[vc] < DEPTH);
    if (v && !acc) merr = 1'b1;
    ones = $countones(g);
    eff = 1'b0; gi = 0;
    if (ones >= 2) merr = 1'b1;
    if (ones == 1) begin
      for (int i = 0; i < NV; i++) if (g[i]) gi = i;
      if (mcnt[gi] > 0) eff = 1'b1; else merr = 1'b1;
    end
    if (acc) mcnt[vc]++;
    if (eff) mcnt[gi]--;
    #1;
    if (full_check) check_outputs(tag);
    @(negedge clk);
    pkt_valid = 1'b0; gnt = '0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  initial begin
    int vcs [3];
    logic [2:0] v_vc;
    logic [7:0] v_g;
    logic       v_v;
    vcs[0] = 0; vcs[1] = 4; vcs[2] = 7;
    pkt_valid = 1'b0; pkt_vc = '0; gnt = '0; clr = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset");
    clr = 1'b0;
    #1;
    check("reset.ready", 64'(pkt_ready), 64'd1);

    // Asynchronous reset mid-traffic with cnt[3]=5.
    for (int i = 0; i < 5; i++) step("rst_fill", 1'b1, 3'd3, 8'h00, 1'b0);
    check_outputs("rst_pre");
    #2;
    clr = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_async");
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("rst_rel.ready", 64'(pkt_ready), 64'd1);

    // Fill VC5 to DEPTH, then overflow.
    for (int i = 0; i < DEPTH; i++) step("fill5", 1'b1, 3'd5, 8'h00, 1'b1);
    check("fill5.full_bit", 64'(full), 64'h20);
    check("fill5.req_bit",  64'(req),  64'h20);
    check("fill5.total8",   64'(total), 64'd8);
    step("ovf5", 1'b1, 3'd5, 8'h00, 1'b1);
    check("ovf5.err", 64'(err), 64'd1);

    // Drain VC5, then grant an empty VC.
    for (int i = 0; i < DEPTH; i++) step("drain5", 1'b0, 3'd0, 8'h20, 1'b1);
    check("drain5.req", 64'(req), 64'h00);
    check("drain5.total", 64'(total), 64'd0);
    do_reset();
    step("under5", 1'b0, 3'd0, 8'h20, 1'b1);
    check("under5.err", 64'(err), 64'd1);

    // Simultaneous arrival and grant on a full VC, then on a partial VC.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 3'd2, 8'h00, 1'b0);
    check_outputs("fill2");
    step("sim_full2", 1'b1, 3'd2, 8'h04, 1'b1);
    check("sim_full2.total7", 64'(total), 64'd7);
    for (int i = 0; i < 4; i++) step("dn2", 1'b0, 3'd0, 8'h04, 1'b0);
    check("dn2.total3", 64'(total), 64'd3);
    step("sim_part2", 1'b1, 3'd2, 8'h04, 1'b1);
    check("sim_part2.total3", 64'(total), 64'd3);

    // Illegal multi-hot grant.
    do_reset();
    step("push7", 1'b1, 3'd7, 8'h00, 1'b1);
    step("push0", 1'b1, 3'd0, 8'h00, 1'b1);
    step("ill81", 1'b0, 3'd0, 8'h81, 1'b1);
    check("ill81.req", 64'(req), 64'h81);
    check("ill81.err", 64'(err), 64'd1);

    // Mixed random traffic on VCs 0, 4, 7; grants land after random delays.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v_v  = ($urandom_range(0, 1) == 1);
      v_vc = 3'(vcs[$urandom_range(0, 2)]);
      v_g  = '0;
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = vcs[$urandom_range(0, 2)];
        if (!(mcnt[k] == 0 && v_v && v_vc == 3'(k))) v_g[k] = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) v_g = 8'h91;
      step("mixed", v_v, v_vc, v_g, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
